// File: rtl/icache_dm_param.sv
// Direct-mapped read-only instruction cache. Optional hit/miss counters are built in when ICACHE_STATS_EN is defined.
// Latency: a hit returns 2 edges after the request is presented; a miss adds the refill handshake time.
// Backpressure: cpu_ready is high only in IDLE with no flush active. The memory request is held until mem_req_ready.
module icache_dm_param #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES      = 8
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 cpu_req_valid,
    input  logic [ADDR_WIDTH-1:0]                cpu_addr,
    output logic                                 cpu_ready,
    output logic                                 instr_valid,
    output logic [WORD_WIDTH-1:0]                instruction,
    output logic                                 hit,
    input  logic                                 flush,
    output logic                                 mem_req_valid,
    output logic [ADDR_WIDTH-1:0]                mem_req_addr,
    input  logic                                 mem_req_ready,
    input  logic                                 mem_resp_valid,
    input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                          hit_count,
    output logic [31:0]                          miss_count
`endif
);

    localparam int BYTE_BITS = $clog2(WORD_WIDTH / 8);
    localparam int OFF_BITS  = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFF_BITS - BYTE_BITS;
    localparam int LINE_LSB  = OFF_BITS + BYTE_BITS;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((64'd1 << LINE_LSB) - 64'd1);

    typedef logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic                    flush_pending_q, flush_pending_d;
    logic                    instr_valid_q, instr_valid_d;
    logic                    hit_q, hit_d;
    logic [WORD_WIDTH-1:0]   instruction_q, instruction_d;
    logic                    mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic                    fill_en;

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
    line_t                   data_q [NUM_LINES];

    logic [OFF_BITS-1:0]     req_off;
    logic [IDX_BITS-1:0]     req_idx;
    logic [TAG_BITS-1:0]     req_tag;
    line_t                   resp_line;
    logic                    lookup_hit;

    assign req_off    = req_addr_q[BYTE_BITS +: OFF_BITS];
    assign req_idx    = req_addr_q[LINE_LSB +: IDX_BITS];
    assign req_tag    = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign resp_line  = mem_resp_data;
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign cpu_ready  = reset_n && (state_q == IDLE) && !flush && !flush_pending_q;

    always_comb begin
        state_d         = state_q;
        req_addr_d      = req_addr_q;
        valid_d         = valid_q;
        flush_pending_d = flush_pending_q | flush;
        instr_valid_d   = 1'b0;
        hit_d           = 1'b0;
        instruction_d   = instruction_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        fill_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_pending_q) begin
                    valid_d         = '0;
                    flush_pending_d = flush;
                end else if (cpu_req_valid && cpu_ready) begin
                    req_addr_d = cpu_addr;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    instr_valid_d = 1'b1;
                    hit_d         = 1'b1;
                    instruction_d = data_q[req_idx][req_off];
                    state_d       = IDLE;
                end else begin
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = req_addr_q & ~LINE_MASK;
                    state_d         = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // The requested word bypasses the array straight from the response bus.
                if (mem_resp_valid) begin
                    fill_en          = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    instr_valid_d    = 1'b1;
                    instruction_d    = resp_line[req_off];
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            req_addr_q      <= '0;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            instr_valid_q   <= 1'b0;
            hit_q           <= 1'b0;
            instruction_q   <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            req_addr_q      <= req_addr_d;
            valid_q         <= valid_d;
            flush_pending_q <= flush_pending_d;
            instr_valid_q   <= instr_valid_d;
            hit_q           <= hit_d;
            instruction_q   <= instruction_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= resp_line;
        end
    end

    assign instr_valid   = instr_valid_q;
    assign hit           = hit_q;
    assign instruction   = instruction_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Counters advance on the same edge as the instr_valid pulse and stick at all-ones.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (instr_valid_d && hit_d && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (instr_valid_d && !hit_d && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
